// File: rtl/alu_vote_retry_ctrl_if.sv
// rtl/alu_vote_retry_ctrl_if.sv - voter-side and consumer-side handshake bundle for alu_vote_retry_ctrl
interface alu_vote_retry_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] voted;
  logic        error_detected;
  logic        invalid_output;
  logic        retry_req;
  logic        retry_busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_fault;

  modport master (
    output in_valid, voted, error_detected, invalid_output, out_ready,
    input  in_ready, retry_req, retry_busy, out_valid, out_data, out_fault
  );

  modport slave (
    input  in_valid, voted, error_detected, invalid_output, out_ready,
    output in_ready, retry_req, retry_busy, out_valid, out_data, out_fault
  );
endinterface

// File: rtl/alu_vote_retry_ctrl.sv
// rtl/alu_vote_retry_ctrl.sv - forwards voted ALU results, re-requests execution on triple disagreement
// Saturating fault statistics are built only when ALU_VOTE_STATS_EN is defined.
module alu_vote_retry_ctrl #(
  parameter int unsigned MAX_RETRIES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_vote_retry_ctrl_if.slave bus,
  input  logic                 clear_stats,
  output logic [CNT_WIDTH-1:0] corrected_count,
  output logic [CNT_WIDTH-1:0] uncorrectable_count
);

  typedef enum logic [1:0] {IDLE, RETRY, HOLD} state_t;

  localparam logic [2:0] MAX_RC = 3'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [2:0]  rc_q, rc_d;
  logic        retry_req_q, retry_req_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_fault_q, out_fault_d;
  logic        inc_corr, inc_unc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rc_q        <= 3'd0;
      retry_req_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      retry_req_q <= retry_req_d;
      out_data_q  <= out_data_d;
      out_fault_q <= out_fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    retry_req_d = 1'b0;
    out_data_d  = out_data_q;
    out_fault_d = out_fault_q;
    inc_corr    = 1'b0;
    inc_unc     = 1'b0;
    case (state_q)
      IDLE, RETRY: begin
        if (bus.in_valid) begin
          if (!bus.invalid_output) begin
            out_data_d  = bus.voted;
            out_fault_d = 1'b0;
            rc_d        = 3'd0;
            state_d     = HOLD;
            inc_corr    = bus.error_detected;
          end else if (rc_q < MAX_RC) begin
            rc_d        = rc_q + 3'd1;
            retry_req_d = 1'b1;
            state_d     = RETRY;
          end else begin
            // Retry budget spent: forward the last vote marked as unrecoverable.
            out_data_d  = bus.voted;
            out_fault_d = 1'b1;
            rc_d        = 3'd0;
            state_d     = HOLD;
            inc_unc     = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready depends only on state, so no input-to-in_ready combinational path exists.
  assign bus.in_ready   = (state_q != HOLD);
  assign bus.retry_busy = (state_q == RETRY);
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.retry_req  = retry_req_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_fault  = out_fault_q;

`ifdef ALU_VOTE_STATS_EN
  logic [CNT_WIDTH-1:0] corr_q, corr_d, unc_q, unc_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      corr_q <= '0;
      unc_q  <= '0;
    end else begin
      corr_q <= corr_d;
      unc_q  <= unc_d;
    end
  end

  // Clear takes priority over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    corr_d = corr_q;
    unc_d  = unc_q;
    if (clear_stats) begin
      corr_d = '0;
      unc_d  = '0;
    end else begin
      if (inc_corr && !(&corr_q)) corr_d = corr_q + CNT_WIDTH'(1);
      if (inc_unc && !(&unc_q))   unc_d  = unc_q + CNT_WIDTH'(1);
    end
  end

  assign corrected_count     = corr_q;
  assign uncorrectable_count = unc_q;
`else
  logic unused_stats;
  assign unused_stats        = ^{clear_stats, inc_corr, inc_unc};
  assign corrected_count     = '0;
  assign uncorrectable_count = '0;
`endif

endmodule

// File: doc/alu_vote_retry_ctrl.md
# alu_vote_retry_ctrl

Sequential stage directly downstream of the 32-bit ternary voter in the fault-tolerant ALU path. It accepts each voted result together with the voter's `errorDetected` and `invalidOutput` flags and forwards clean or single-fault-corrected results to the consumer over a valid/ready handshake. When all three replicas disagree, it requests re-execution from the upstream issue logic, up to a bounded number of retries, then forwards the result with a fault flag. It optionally keeps saturating fault statistics.

## Interface
- `MAX_RETRIES`, 2: re-execution requests allowed per operation, 0..7; 0 disables retry.
- `CNT_WIDTH`, 16: width of each statistics counter.

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  voter result present this cycle
- `in_ready`  out  1  block can accept a voter result
- `voted`  in  32  voter `out`
- `error_detected`  in  1  voter `errorDetected`
- `invalid_output`  in  1  voter `invalidOutput`
- `retry_req`  out  1  one-cycle pulse: upstream re-executes the current operation
- `retry_busy`  out  1  waiting for a re-executed result
- `out_valid`  out  1  result held for the consumer
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  32  registered result
- `out_fault`  out  1  result is unrecoverable (retries exhausted)
- `clear_stats`  in  1  synchronous clear of the statistics counters
- `corrected_count`  out  CNT_WIDTH  accepted results with `error_detected`=1 and `invalid_output`=0
- `uncorrectable_count`  out  CNT_WIDTH  results forwarded with `out_fault`=1

## Operation
- FSM states: IDLE, RETRY, HOLD. Reset state is IDLE.
- Reset values: `in_ready`=1, `retry_req`=0, `retry_busy`=0, `out_valid`=0, `out_data`=0, `out_fault`=0, both counters=0. The internal retry counter `rc` resets to 0.
- A result is accepted when `in_valid` & `in_ready`. `in_ready`=1 in IDLE and RETRY, and 0 in HOLD.
- Evaluation of an accepted result is the same in IDLE and RETRY:
  - `invalid_output`=0: latch `voted` into `out_data`, set `out_fault`=0, clear `rc`, go to HOLD. If `error_detected`=1, increment `corrected_count`.
  - `invalid_output`=1 and `rc` < `MAX_RETRIES`: increment `rc`, pulse `retry_req`, go to RETRY. `out_data` is not updated.
  - `invalid_output`=1 and `rc` = `MAX_RETRIES`: latch `voted`, set `out_fault`=1, clear `rc`, increment `uncorrectable_count`, go to HOLD.
- RETRY: `retry_busy`=1. The block waits for the re-executed result with no timeout.
- HOLD: `out_valid`=1, and `out_data`/`out_fault` are stable. When `out_ready`=1, the block returns to IDLE.
- Counters saturate at all-ones and do not wrap.
- `clear_stats` zeroes both counters on the next edge. If an increment occurs in the same cycle, clear wins and the count is 0.
- `error_detected` with `invalid_output`=1 is not counted as corrected.

## Timing
- Acceptance at edge N: `out_valid` or `retry_busy` is high from after edge N.
- `retry_req` is registered. It is high for exactly the one cycle following the accepting edge.
- Handshake completes at edge M when `out_valid` & `out_ready`. `in_ready` is high after M.
- There is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `in_ready`.
- Peak throughput is one result per 2 cycles.
- An asynchronous `reset` mid-operation (RETRY or HOLD) returns all outputs to their reset values immediately. The pending operation is dropped with no `retry_req`.

## Configuration
- `ALU_VOTE_STATS_EN` defined: both counters and the `clear_stats` logic are implemented as described.
- `ALU_VOTE_STATS_EN` undefined: no counter flops. `corrected_count` and `uncorrectable_count` are tied to 0, and `clear_stats` is ignored. FSM, handshake, and retry behaviour are unchanged.

## Test plan
- Clean result: `voted`=0x1234_5678, both flags 0, `out_ready`=1 → `out_valid` one cycle later, `out_data`=0x1234_5678, `out_fault`=0, counters unchanged.
- Corrected result: `error_detected`=1, `invalid_output`=0, `voted`=0xDEAD_BEEF → forwarded with `out_fault`=0, `corrected_count`=1.
- Retry recovery (`MAX_RETRIES`=2): invalid, then invalid, then clean 0x0000_00AA → exactly two `retry_req` pulses, `retry_busy` high between them, `out_data`=0xAA, `out_fault`=0.
- Retry exhaustion (`MAX_RETRIES`=2): three invalid results, last `voted`=0xFFFF_0000 → two `retry_req` pulses, then `out_fault`=1, `out_data`=0xFFFF_0000, `uncorrectable_count`=1. Next operation starts with `rc`=0.
- Backpressure and saturation (`CNT_WIDTH`=2): hold `out_ready`=0 for 5 cycles → `in_ready`=0 and outputs stable. Five corrected results → `corrected_count`=3. `clear_stats` concurrent with a corrected result → count 0.
- Reset mid-RETRY: assert `reset` while `retry_busy`=1 → all outputs at reset values without waiting for a clock edge. The next clean input is accepted normally.
